pac_game_ctrl: RTL and testbench

Frame-rate game sequencer for the Pac-Man mover. It owns the game state (idle, play, death, respawn, win, over) and drives `playon` to the mover. It buffers WASD turns until the wall flags permit them and issues the per-frame motion vector at a programmable step rate. It sits between the keyboard keycode register and the mover, and feeds it `playon`, `x_motion`/`y_motion` and `whichside`.

---
 rtl/pac_game_ctrl.sv | 134 +++++++++++++
 tb/tb_pac_game_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pac_game_ctrl.sv
// pac_game_ctrl: frame-rate game sequencer driving playon, motion and facing to the Pac-Man mover
module pac_game_ctrl #(
    parameter int STEP_DIV     = 1,
    parameter int DEATH_FRAMES = 60,
    parameter int LIVES_INIT   = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       leftwall,
    input  logic       rightwall,
    input  logic       downwall,
    input  logic       upwall,
    input  logic       ghost_hit,
    input  logic       dots_done,
    output logic       playon,
    output logic [9:0] x_motion,
    output logic [9:0] y_motion,
    output logic [1:0] whichside,
    output logic [1:0] lives,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_DEATH   = 3'd2,
        S_RESPAWN = 3'd3,
        S_WIN     = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [1:0] pend_dir_q, pend_dir_d, cur_dir_q, cur_dir_d;
    logic       pend_vld_q, pend_vld_d, cur_vld_q, cur_vld_d;
    logic [7:0] div_q, div_d, dcnt_q, dcnt_d;
    logic [9:0] xm_q, xm_d, ym_q, ym_d;
    logic       playon_q, playon_d;
    logic [3:0] walls;
    logic [1:0] key_dir;
    logic       key_vld, start, tick, death_done, commit, move;

    // Next-state: game FSM, turn buffer, step divider, death timer and motion vector
    always_comb begin
        walls      = {upwall, downwall, rightwall, leftwall};
        start      = keycode == 8'h2C;
        key_vld    = keycode == 8'h04 || keycode == 8'h07 || keycode == 8'h16 || keycode == 8'h1A;
        key_dir    = keycode == 8'h04 ? 2'd0 : keycode == 8'h07 ? 2'd1 : keycode == 8'h16 ? 2'd2 : 2'd3;
        tick       = div_q == 8'(STEP_DIV - 1);
        death_done = dcnt_q == 8'(DEATH_FRAMES - 1);
        commit     = pend_vld_q && walls[pend_dir_q];
        move       = state_q == S_PLAY && tick && cur_vld_q && walls[cur_dir_q];
        state_d    = state_q;
        lives_d    = lives_q;
        case (state_q)
            S_IDLE:    state_d = start ? S_PLAY : S_IDLE;
            S_PLAY: begin
                if (dots_done) begin
                    state_d = S_WIN;
                end else if (ghost_hit) begin
                    state_d = S_DEATH;
                    lives_d = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
                end
            end
            S_DEATH:   state_d = !death_done ? S_DEATH : lives_q == 2'd0 ? S_OVER : S_RESPAWN;
            S_RESPAWN: state_d = S_PLAY;
            S_WIN, S_OVER: begin
                if (start) begin
                    state_d = S_IDLE;
                    lives_d = 2'(LIVES_INIT);
                end
            end
            default:   state_d = S_IDLE;
        endcase
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        cur_dir_d  = cur_dir_q;
        cur_vld_d  = cur_vld_q;
        if (state_q == S_PLAY) begin
            cur_dir_d  = commit ? pend_dir_q : cur_dir_q;
            cur_vld_d  = commit || cur_vld_q;
            pend_dir_d = key_vld ? key_dir : pend_dir_q;
            pend_vld_d = key_vld || (pend_vld_q && !commit);
        end
        if (state_d == S_IDLE || state_d == S_RESPAWN) begin
            pend_dir_d = 2'd0;
            pend_vld_d = 1'b0;
            cur_dir_d  = 2'd0;
            cur_vld_d  = 1'b0;
        end
        div_d = state_q == S_PLAY ? (tick ? 8'd0 : div_q + 8'd1) : div_q;
        if (state_d == S_PLAY && state_q != S_PLAY) div_d = 8'd0;
        dcnt_d   = (state_q == S_DEATH && state_d == S_DEATH) ? dcnt_q + 8'd1 : 8'd0;
        xm_d     = !move ? 10'd0 : cur_dir_q == 2'd0 ? 10'h3FF : cur_dir_q == 2'd1 ? 10'h001 : 10'd0;
        ym_d     = !move ? 10'd0 : cur_dir_q == 2'd2 ? 10'h001 : cur_dir_q == 2'd3 ? 10'h3FF : 10'd0;
        playon_d = state_d == S_PLAY || state_d == S_DEATH;
    end

    // State registers with synchronous reset
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            lives_q    <= 2'(LIVES_INIT);
            pend_dir_q <= 2'd0;
            pend_vld_q <= 1'b0;
            cur_dir_q  <= 2'd0;
            cur_vld_q  <= 1'b0;
            div_q      <= 8'd0;
            dcnt_q     <= 8'd0;
            xm_q       <= 10'd0;
            ym_q       <= 10'd0;
            playon_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            pend_dir_q <= pend_dir_d;
            pend_vld_q <= pend_vld_d;
            cur_dir_q  <= cur_dir_d;
            cur_vld_q  <= cur_vld_d;
            div_q      <= div_d;
            dcnt_q     <= dcnt_d;
            xm_q       <= xm_d;
            ym_q       <= ym_d;
            playon_q   <= playon_d;
        end
    end

    assign state     = state_q;
    assign playon    = playon_q;
    assign x_motion  = xm_q;
    assign y_motion  = ym_q;
    assign whichside = cur_dir_q;
    assign lives     = lives_q;
endmodule

// File: tb/tb_pac_game_ctrl.sv
// tb_pac_game_ctrl: randomized scoreboard bench for two differently parameterized sequencers
module tb_pac_game_ctrl;
    localparam int SD0 = 1, DF0 = 3,  LI0 = 3;
    localparam int SD1 = 4, DF1 = 60, LI1 = 2;
    localparam int NCYC = 6000;
    localparam logic [7:0] KEYS[4] = '{8'h04, 8'h07, 8'h16, 8'h1A};
    localparam int DX[4] = '{-1, 1, 0, 0};
    localparam int DY[4] = '{0, 0, 1, -1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key = 8'h00;
    logic       lw = 1'b1, rw = 1'b1, dw = 1'b1, uw = 1'b1;
    logic       gh = 1'b0, dd = 1'b0;
    logic [2:0] st_o[2];
    logic       po_o[2];
    logic [9:0] xm_o[2], ym_o[2];
    logic [1:0] ws_o[2], lv_o[2];

    logic [27:0] q0[$], q1[$];
    int n_pass = 0, n_tot = 0, n_prt = 0;

    int m_st[2], m_lv[2], m_pd[2], m_cd[2], m_div[2], m_dc[2];
    bit m_pv[2], m_cv[2];
    int sd[2] = '{SD0, SD1};
    int df[2] = '{DF0, DF1};
    int li[2] = '{LI0, LI1};

    always #5 clk = ~clk;

    pac_game_ctrl #(.STEP_DIV(SD0), .DEATH_FRAMES(DF0), .LIVES_INIT(LI0)) u0 (
        .frame_clk(clk), .Reset(rst), .keycode(key),
        .leftwall(lw), .rightwall(rw), .downwall(dw), .upwall(uw),
        .ghost_hit(gh), .dots_done(dd),
        .playon(po_o[0]), .x_motion(xm_o[0]), .y_motion(ym_o[0]),
        .whichside(ws_o[0]), .lives(lv_o[0]), .state(st_o[0]));

    pac_game_ctrl #(.STEP_DIV(SD1), .DEATH_FRAMES(DF1), .LIVES_INIT(LI1)) u1 (
        .frame_clk(clk), .Reset(rst), .keycode(key),
        .leftwall(lw), .rightwall(rw), .downwall(dw), .upwall(uw),
        .ghost_hit(gh), .dots_done(dd),
        .playon(po_o[1]), .x_motion(xm_o[1]), .y_motion(ym_o[1]),
        .whichside(ws_o[1]), .lives(lv_o[1]), .state(st_o[1]));

    // Reference model: advance one frame from the game rules and return the expected outputs
    task automatic model_step(input int i, output logic [27:0] e);
        bit w[4];
        int kd, nst, nlv, mx, my;
        bit commit;
        w = '{lw, rw, dw, uw};
        kd = -1;
        for (int k = 0; k < 4; k++) if (key == KEYS[k]) kd = k;
        if (rst) begin
            m_st[i] = 0; m_lv[i] = li[i]; m_pd[i] = 0; m_cd[i] = 0;
            m_pv[i] = 0; m_cv[i] = 0; m_div[i] = 0; m_dc[i] = 0;
            e = {3'd0, 1'b0, 10'd0, 10'd0, 2'd0, 2'(li[i])};
            return;
        end
        nst = m_st[i];
        nlv = m_lv[i];
        case (m_st[i])
            0: if (key == 8'h2C) nst = 1;
            1: if (dd) nst = 4; else if (gh) begin nst = 2; nlv = m_lv[i] > 0 ? m_lv[i] - 1 : 0; end
            2: if (m_dc[i] + 1 == df[i]) nst = (m_lv[i] == 0) ? 5 : 3;
            3: nst = 1;
            default: if (key == 8'h2C) begin nst = 0; nlv = li[i]; end
        endcase
        mx = 0;
        my = 0;
        if (m_st[i] == 1 && m_div[i] == sd[i] - 1 && m_cv[i] && w[m_cd[i]]) begin
            mx = DX[m_cd[i]];
            my = DY[m_cd[i]];
        end
        if (m_st[i] == 1) begin
            commit = m_pv[i] && w[m_pd[i]];
            if (commit) begin m_cd[i] = m_pd[i]; m_cv[i] = 1; end
            if (kd >= 0) begin m_pd[i] = kd; m_pv[i] = 1; end
            else if (commit) m_pv[i] = 0;
            m_div[i] = (m_div[i] + 1) % sd[i];
        end
        if (nst == 0 || nst == 3) begin
            m_pd[i] = 0; m_cd[i] = 0; m_pv[i] = 0; m_cv[i] = 0;
        end
        if (nst == 1 && m_st[i] != 1) m_div[i] = 0;
        m_dc[i] = (m_st[i] == 2 && nst == 2) ? m_dc[i] + 1 : 0;
        m_st[i] = nst;
        m_lv[i] = nlv;
        e = {3'(nst), 1'(nst == 1 || nst == 2), 10'(mx), 10'(my), 2'(m_cd[i]), 2'(nlv)};
    endtask

    task automatic check(input int i, input logic [27:0] got, input logic [27:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else if (n_prt < 25) begin
            n_prt++;
            $display("FAIL outputs_u%0d t=%0t got st=%0d po=%0b x=%h y=%h side=%0d lives=%0d exp st=%0d po=%0b x=%h y=%h side=%0d lives=%0d",
                     i, $time, got[27:25], got[24], got[23:14], got[13:4], got[3:2], got[1:0],
                     exp[27:25], exp[24], exp[23:14], exp[13:4], exp[3:2], exp[1:0]);
        end
    endtask

    // Monitor: pop one expected frame per instance after each edge and compare
    initial begin
        logic [27:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check(0, {st_o[0], po_o[0], xm_o[0], ym_o[0], ws_o[0], lv_o[0]}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check(1, {st_o[1], po_o[1], xm_o[1], ym_o[1], ws_o[1], lv_o[1]}, e);
            end
        end
    end

    // Driver: randomized inputs with sticky walls and held keys, expectations pushed per frame
    initial begin
        logic [27:0] e;
        int r;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst = (c < 2) || ($urandom_range(0, 399) == 0);
            r = $urandom_range(0, 9);
            if (r >= 4 && r <= 7) key = KEYS[$urandom_range(0, 3)];
            else if (r == 8) key = 8'h2C;
            else if (r == 9) key = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) lw = ~lw;
            if ($urandom_range(0, 5) == 0) rw = ~rw;
            if ($urandom_range(0, 5) == 0) dw = ~dw;
            if ($urandom_range(0, 5) == 0) uw = ~uw;
            gh = $urandom_range(0, 24) == 0;
            dd = $urandom_range(0, 59) == 0;
            model_step(0, e);
            q0.push_back(e);
            model_step(1, e);
            q1.push_back(e);
        end
        @(negedge clk);
        @(negedge clk);
        n_tot++;
        if (q0.size() + q1.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending exp 0", q0.size() + q1.size());
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
